// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - pipeline stall/flush control with load-use, redirect, imem wait and dmem freeze
module hazard_stall_controller #(
    parameter int LOAD_USE_PENALTY = 1,
    parameter int PERF_WIDTH       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            id_rs1,
    input  logic [4:0]            id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [4:0]            ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_redirect,
    input  logic                  imem_ready,
    input  logic                  dmem_busy,
    output logic                  pc_stall,
    output logic                  fd_stall,
    output logic                  fd_flush,
    output logic                  de_stall,
    output logic                  de_flush,
    output logic                  em_stall,
    output logic [PERF_WIDTH-1:0] stall_cycles,
    output logic [PERF_WIDTH-1:0] flush_events
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } state_t;

    localparam logic [1:0]            LU_INIT  = 2'(LOAD_USE_PENALTY - 1);
    localparam logic [PERF_WIDTH-1:0] PERF_ONE = PERF_WIDTH'(1);

    state_t                state_q, state_d;
    state_t                saved_q, saved_d;
    state_t                eff_state;
    logic [1:0]            lu_cnt_q, lu_cnt_d;
    logic [PERF_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
    logic [PERF_WIDTH-1:0] flush_events_q, flush_events_d;
    logic                  lu_hit;
    logic                  redirect_taken;

    // Load-use detect; the state seen through a freeze is the one saved on entry, so
    // the cycle dmem_busy drops already behaves as the resumed state.
    always_comb begin
        lu_hit = ex_mem_read && (ex_rd != 5'd0) &&
                 ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                  (id_uses_rs2 && (id_rs2 == ex_rd)));
        eff_state = (state_q == ST_MEM_WAIT) ? saved_q : state_q;
    end

    // Next-state and control decode, priority: dmem freeze, redirect, load-use, imem wait.
    always_comb begin
        pc_stall       = 1'b0;
        fd_stall       = 1'b0;
        fd_flush       = 1'b0;
        de_stall       = 1'b0;
        de_flush       = 1'b0;
        em_stall       = 1'b0;
        redirect_taken = 1'b0;
        state_d        = state_q;
        saved_d        = saved_q;
        lu_cnt_d       = lu_cnt_q;
        if (dmem_busy) begin
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            de_stall = 1'b1;
            em_stall = 1'b1;
            state_d  = ST_MEM_WAIT;
            saved_d  = eff_state;
        end else if (ex_redirect) begin
            fd_flush       = 1'b1;
            de_flush       = 1'b1;
            redirect_taken = 1'b1;
            state_d        = ST_RUN;
            saved_d        = ST_RUN;
            lu_cnt_d       = 2'd0;
        end else if (eff_state == ST_LOAD_STALL) begin
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            de_flush = 1'b1;
            lu_cnt_d = lu_cnt_q - 2'd1;
            if (lu_cnt_q <= 2'd1) begin
                state_d  = ST_RUN;
                lu_cnt_d = 2'd0;
            end else begin
                state_d = ST_LOAD_STALL;
            end
        end else if (lu_hit) begin
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            de_flush = 1'b1;
            if (LOAD_USE_PENALTY > 1) begin
                state_d  = ST_LOAD_STALL;
                lu_cnt_d = LU_INIT;
            end else begin
                state_d = ST_RUN;
            end
        end else if (!imem_ready) begin
            pc_stall = 1'b1;
            fd_flush = 1'b1;
            state_d  = ST_RUN;
        end else begin
            state_d = ST_RUN;
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (pc_stall && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + PERF_ONE;
        end
        if (redirect_taken && !(&flush_events_q)) begin
            flush_events_d = flush_events_q + PERF_ONE;
        end
    end

    // State, saved state, load-use counter and perf counters; async reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_RUN;
            saved_q        <= ST_RUN;
            lu_cnt_q       <= 2'd0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q        <= state_d;
            saved_q        <= saved_d;
            lu_cnt_q       <= lu_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - directed self-checking bench for hazard_stall_controller
module tb_hazard_stall_controller;

    localparam logic [5:0] C_NONE   = 6'b000000;
    localparam logic [5:0] C_LU     = 6'b110010;
    localparam logic [5:0] C_FREEZE = 6'b110101;
    localparam logic [5:0] C_REDIR  = 6'b001010;
    localparam logic [5:0] C_IMEM   = 6'b101000;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_redirect;
    logic       imem_ready;
    logic       dmem_busy;

    logic        a_pc_stall, a_fd_stall, a_fd_flush, a_de_stall, a_de_flush, a_em_stall;
    logic [1:0]  a_stall_cycles, a_flush_events;
    logic        b_pc_stall, b_fd_stall, b_fd_flush, b_de_stall, b_de_flush, b_em_stall;
    logic [31:0] b_stall_cycles, b_flush_events;
    logic [5:0]  ctrl_a, ctrl_b;

    int checks = 0;
    int errors = 0;

    assign ctrl_a = {a_pc_stall, a_fd_stall, a_fd_flush, a_de_stall, a_de_flush, a_em_stall};
    assign ctrl_b = {b_pc_stall, b_fd_stall, b_fd_flush, b_de_stall, b_de_flush, b_em_stall};

    hazard_stall_controller #(.LOAD_USE_PENALTY(1), .PERF_WIDTH(2)) dut_a (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .imem_ready(imem_ready), .dmem_busy(dmem_busy),
        .pc_stall(a_pc_stall), .fd_stall(a_fd_stall), .fd_flush(a_fd_flush),
        .de_stall(a_de_stall), .de_flush(a_de_flush), .em_stall(a_em_stall),
        .stall_cycles(a_stall_cycles), .flush_events(a_flush_events)
    );

    hazard_stall_controller #(.LOAD_USE_PENALTY(3), .PERF_WIDTH(32)) dut_b (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .imem_ready(imem_ready), .dmem_busy(dmem_busy),
        .pc_stall(b_pc_stall), .fd_stall(b_fd_stall), .fd_flush(b_fd_flush),
        .de_stall(b_de_stall), .de_flush(b_de_flush), .em_stall(b_em_stall),
        .stall_cycles(b_stall_cycles), .flush_events(b_flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs1      = 5'd0;
        id_rs2      = 5'd0;
        id_uses_rs1 = 1'b0;
        id_uses_rs2 = 1'b0;
        ex_rd       = 5'd0;
        ex_mem_read = 1'b0;
        ex_redirect = 1'b0;
        imem_ready  = 1'b1;
        dmem_busy   = 1'b0;
    endtask

    task automatic lu(input logic [4:0] r);
        ex_mem_read = 1'b1;
        ex_rd       = r;
        id_rs1      = r;
        id_uses_rs1 = 1'b1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #2;
        chk("reset_ctrl_a", ctrl_a, C_NONE);
        chk("reset_ctrl_b", ctrl_b, C_NONE);
        chk("reset_stall_b", b_stall_cycles, 0);
        chk("reset_flush_b", b_flush_events, 0);
        lu(5'd5);
        #1;
        chk("reset_run_decode_b", ctrl_b, C_LU);
        @(negedge clk);
        chk("reset_holds_counter", b_stall_cycles, 0);
        idle();
        rst = 1'b0;

        // load-use, both penalties
        next_cycle(); lu(5'd5); #1;
        chk("lu1_ctrl_a", ctrl_a, C_LU);
        chk("lu1_ctrl_b", ctrl_b, C_LU);
        next_cycle(); #1;
        chk("lu2_ctrl_a", ctrl_a, C_NONE);
        chk("lu2_ctrl_b", ctrl_b, C_LU);
        chk("lu2_stall_a", a_stall_cycles, 1);
        chk("lu2_stall_b", b_stall_cycles, 1);
        next_cycle(); #1;
        chk("lu3_ctrl_b", ctrl_b, C_LU);
        chk("lu3_stall_b", b_stall_cycles, 2);
        next_cycle(); #1;
        chk("lu4_ctrl_a", ctrl_a, C_NONE);
        chk("lu4_ctrl_b", ctrl_b, C_NONE);
        chk("lu4_stall_b", b_stall_cycles, 3);

        // x0 and no-use filtering, then an rs2 hit
        next_cycle(); lu(5'd0); #1;
        chk("x0_ctrl_a", ctrl_a, C_NONE);
        chk("x0_ctrl_b", ctrl_b, C_NONE);
        next_cycle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs1 = 5'd7; #1;
        chk("nouse_ctrl_a", ctrl_a, C_NONE);
        chk("nouse_ctrl_b", ctrl_b, C_NONE);
        next_cycle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1; #1;
        chk("rs2_ctrl_a", ctrl_a, C_LU);
        chk("rs2_ctrl_b", ctrl_b, C_LU);
        next_cycle(); #1;
        chk("rs2b_ctrl_a", ctrl_a, C_NONE);
        chk("rs2b_ctrl_b", ctrl_b, C_LU);
        chk("rs2b_stall_a", a_stall_cycles, 2);
        next_cycle(); #1;
        chk("rs2c_ctrl_b", ctrl_b, C_LU);
        next_cycle(); #1;
        chk("rs2d_ctrl_b", ctrl_b, C_NONE);
        chk("rs2d_stall_b", b_stall_cycles, 6);

        // redirect aborts a stall in its 2nd cycle
        next_cycle(); lu(5'd5); #1;
        chk("rd1_ctrl_b", ctrl_b, C_LU);
        next_cycle(); ex_redirect = 1'b1; #1;
        chk("rd2_ctrl_a", ctrl_a, C_REDIR);
        chk("rd2_ctrl_b", ctrl_b, C_REDIR);
        chk("rd2_stall_a", a_stall_cycles, 3);
        next_cycle(); #1;
        chk("rd3_ctrl_b", ctrl_b, C_NONE);
        chk("rd3_flush_a", a_flush_events, 1);
        chk("rd3_flush_b", b_flush_events, 1);
        chk("rd3_stall_b", b_stall_cycles, 7);

        // reset, then a 4-cycle freeze in the middle of a penalty-3 stall
        next_cycle(); rst = 1'b1; #1;
        chk("rp_stall_b", b_stall_cycles, 0);
        chk("rp_flush_b", b_flush_events, 0);
        chk("rp_stall_a", a_stall_cycles, 0);
        next_cycle(); rst = 1'b0; lu(5'd5); #1;
        chk("fz1_ctrl_b", ctrl_b, C_LU);
        next_cycle(); #1;
        chk("fz2_ctrl_a", ctrl_a, C_NONE);
        chk("fz2_ctrl_b", ctrl_b, C_LU);
        for (int i = 0; i < 4; i++) begin
            next_cycle(); dmem_busy = 1'b1; ex_redirect = (i == 1); #1;
            chk("fz_ctrl_a", ctrl_a, C_FREEZE);
            chk("fz_ctrl_b", ctrl_b, C_FREEZE);
        end
        next_cycle(); #1;
        chk("fz7_ctrl_a", ctrl_a, C_NONE);
        chk("fz7_ctrl_b", ctrl_b, C_LU);
        chk("fz7_stall_a_sat", a_stall_cycles, 3);
        chk("fz7_stall_b", b_stall_cycles, 6);
        next_cycle(); #1;
        chk("fz8_ctrl_b", ctrl_b, C_NONE);
        chk("fz8_stall_b", b_stall_cycles, 7);
        chk("fz8_flush_b", b_flush_events, 0);
        chk("fz8_flush_a", a_flush_events, 0);

        // imem wait for two cycles
        next_cycle(); imem_ready = 1'b0; #1;
        chk("im1_ctrl_a", ctrl_a, C_IMEM);
        chk("im1_ctrl_b", ctrl_b, C_IMEM);
        next_cycle(); imem_ready = 1'b0; #1;
        chk("im2_ctrl_b", ctrl_b, C_IMEM);
        chk("im2_stall_b", b_stall_cycles, 8);
        next_cycle(); #1;
        chk("im3_ctrl_b", ctrl_b, C_NONE);
        chk("im3_stall_b", b_stall_cycles, 9);

        // redirect outranks load-use and imem wait
        next_cycle(); lu(5'd5); ex_redirect = 1'b1; imem_ready = 1'b0; #1;
        chk("pri_ctrl_a", ctrl_a, C_REDIR);
        chk("pri_ctrl_b", ctrl_b, C_REDIR);
        next_cycle(); #1;
        chk("pri2_ctrl_b", ctrl_b, C_NONE);
        chk("pri2_flush_b", b_flush_events, 1);

        // reset in the middle of LOAD_STALL
        next_cycle(); lu(5'd5); #1;
        chk("rs1_ctrl_b", ctrl_b, C_LU);
        next_cycle(); rst = 1'b1; #1;
        chk("rs2_ctrl_b", ctrl_b, C_NONE);
        chk("rs2_stall_b", b_stall_cycles, 0);
        chk("rs2_flush_b", b_flush_events, 0);
        next_cycle(); rst = 1'b0; #1;
        chk("rs3_ctrl_b", ctrl_b, C_NONE);

        // reset in the middle of MEM_WAIT
        next_cycle(); lu(5'd5); #1;
        chk("rm1_ctrl_b", ctrl_b, C_LU);
        next_cycle(); dmem_busy = 1'b1; #1;
        chk("rm2_ctrl_b", ctrl_b, C_FREEZE);
        next_cycle(); rst = 1'b1; #1;
        chk("rm3_ctrl_b", ctrl_b, C_NONE);
        next_cycle(); rst = 1'b0; #1;
        chk("rm4_ctrl_a", ctrl_a, C_NONE);
        chk("rm4_ctrl_b", ctrl_b, C_NONE);
        chk("rm4_stall_b", b_stall_cycles, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
